if_id_buffer: RTL and testbench

Fetch-to-decode pipeline buffer. It sits directly downstream of the program-counter register and instruction memory, and upstream of the decode stage. It captures each fetched beat (PC plus instruction word) under a valid/ready handshake and presents it to decode together with PC+4. It absorbs decode stalls without dropping or duplicating beats, and discards all held beats on a branch/jump flush.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/if_id_slot.sv | 39 +++
 rtl/if_id_buffer.sv | 180 ++++++++++++++++++
 tb/tb_if_id_buffer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared fetch-stage types and constants (beat layout, IF/ID states).
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;
   localparam int PC_STEP        = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W_DEFAULT-1:0] pc;
      logic [DATA_W_DEFAULT-1:0] instr;
   } beat_t;

endpackage
`default_nettype wire

// File: rtl/if_id_slot.sv
`default_nettype none
// ============================================================================
// Module   : if_id_slot
// Purpose  : Load-enabled fetch-beat register (PC + instruction), async reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_slot
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [DATA_W-1:0] instr_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] instr_o
);

   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] instr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else if (ld_i) begin
         pc_q    <= pc_i;
         instr_q <= instr_i;
      end
   end

   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buffer
// Purpose  : Fetch-to-decode buffer; main slot plus optional skid slot (IF_ID_SKID_EN).
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buffer
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_valid,
   output logic              f_ready,
   input  logic [ADDR_W-1:0] f_pc,
   input  logic [DATA_W-1:0] f_instr,
   input  logic              flush,
   output logic              d_valid,
   input  logic              d_ready,
   output logic [ADDR_W-1:0] d_pc,
   output logic [ADDR_W-1:0] d_pc4,
   output logic [DATA_W-1:0] d_instr,
   output logic [1:0]        count
);

   state_e            state_q, state_d;
   logic              main_ld;
   logic [ADDR_W-1:0] main_pc_d, main_pc_q;
   logic [DATA_W-1:0] main_instr_d, main_instr_q;
   logic              in_xfer, out_xfer;

   assign d_valid  = (state_q != EMPTY);
   assign in_xfer  = f_valid & f_ready;
   assign out_xfer = d_valid & d_ready;

`ifdef IF_ID_SKID_EN
   logic              skid_ld, main_from_skid;
   logic              f_ready_q, f_ready_d;
   logic [ADDR_W-1:0] skid_pc_q;
   logic [DATA_W-1:0] skid_instr_q;

   always_comb begin
      state_d        = state_q;
      main_ld        = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_d = FULL;
               skid_ld = 1'b1;
            end else if (in_xfer && out_xfer) begin
               main_ld = 1'b1;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (out_xfer) begin
               state_d        = ONE;
               main_ld        = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins; payload loads are suppressed since their contents no longer matter.
      if (flush) begin
         state_d        = EMPTY;
         main_ld        = 1'b0;
         main_from_skid = 1'b0;
         skid_ld        = 1'b0;
      end
   end

   assign f_ready_d = (state_d != FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_ready_q <= 1'b0;
      end else begin
         f_ready_q <= f_ready_d;
      end
   end

   assign f_ready      = f_ready_q;
   assign main_pc_d    = main_from_skid ? skid_pc_q    : f_pc;
   assign main_instr_d = main_from_skid ? skid_instr_q : f_instr;

   if_id_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_i    (skid_ld),
      .pc_i    (f_pc),
      .instr_i (f_instr),
      .pc_o    (skid_pc_q),
      .instr_o (skid_instr_q)
   );
`else
   logic rst_rel_q;

   always_comb begin
      state_d = state_q;
      main_ld = 1'b0;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_ld = 1'b1;
            end
         end
         ONE: begin
            if (in_xfer) begin
               main_ld = 1'b1;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
         main_ld = 1'b0;
      end
   end

   // Holds f_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_rel_q <= 1'b0;
      end else begin
         rst_rel_q <= 1'b1;
      end
   end

   assign f_ready      = rst_rel_q & (!d_valid | d_ready);
   assign main_pc_d    = f_pc;
   assign main_instr_d = f_instr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   if_id_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_main_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_i    (main_ld),
      .pc_i    (main_pc_d),
      .instr_i (main_instr_d),
      .pc_o    (main_pc_q),
      .instr_o (main_instr_q)
   );

   assign d_pc    = main_pc_q;
   assign d_instr = main_instr_q;
   // Gated so the idle/reset value reads 0 rather than PC_STEP.
   assign d_pc4   = d_valid ? (main_pc_q + ADDR_W'(PC_STEP)) : '0;
   assign count   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buffer
// Purpose  : Scoreboard bench for if_id_buffer (both IF_ID_SKID_EN builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_valid = 1'b0;
   logic        flush = 1'b0;
   logic        d_ready = 1'b0;
   logic [31:0] f_pc = '0;
   logic [31:0] f_instr = '0;
   logic        f_ready, d_valid;
   logic [31:0] d_pc, d_pc4, d_instr;
   logic [1:0]  count;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   mon_en  = 1'b0;

   if_id_buffer #(
      .ADDR_W (32),
      .DATA_W (32)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .f_valid (f_valid),
      .f_ready (f_ready),
      .f_pc    (f_pc),
      .f_instr (f_instr),
      .flush   (flush),
      .d_valid (d_valid),
      .d_ready (d_ready),
      .d_pc    (d_pc),
      .d_pc4   (d_pc4),
      .d_instr (d_instr),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // The presented beat must always be the oldest outstanding expected beat.
   always @(negedge clk) begin
      if (mon_en && rst_n && d_valid) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got pc 0x%08h expected none", d_pc);
         end else begin
            check("d_pc", d_pc, sb[0].pc);
            check("d_instr", d_instr, sb[0].instr);
            check("d_pc4", d_pc4, sb[0].pc4);
            if (d_ready) void'(sb.pop_front());
         end
      end
   end

   // One clock of stimulus; expected beats are queued at the edge they are accepted.
   task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic dr, input logic fl);
      logic acc;
      f_valid = fv;
      f_pc    = pc;
      f_instr = ins;
      d_ready = dr;
      flush   = fl;
      @(negedge clk);
      acc = f_valid & f_ready;
      @(posedge clk);
      if (fl) sb.delete();
      else if (acc) sb.push_back('{pc: pc, instr: ins, pc4: pc4});
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with fetch already offering a beat
      rst_n   = 1'b0;
      f_valid = 1'b1;
      f_pc    = 32'h40;
      f_instr = 32'hEE;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_d_valid", {31'b0, d_valid}, 32'h0);
         check("rst_d_pc", d_pc, 32'h0);
         check("rst_d_instr", d_instr, 32'h0);
         check("rst_d_pc4", d_pc4, 32'h0);
         check("rst_f_ready", {31'b0, f_ready}, 32'h0);
         check("rst_count", {30'b0, count}, 32'h0);
      end
      rst_n = 1'b1;
      #1;
      check("rel_f_ready_pre", {31'b0, f_ready}, 32'h0);
      @(posedge clk);
      #1;
      f_valid = 1'b0;
      #1;
      check("rel_f_ready_post", {31'b0, f_ready}, 32'h1);
      check("rel_d_valid", {31'b0, d_valid}, 32'h0);
      mon_en = 1'b1;

      // Stream, no gaps
      cycle(1'b1, 32'h0, 32'hA0, 32'h4, 1'b1, 1'b0);
      check("stream_valid0", {31'b0, d_valid}, 32'h1);
      cycle(1'b1, 32'h4, 32'hA1, 32'h8, 1'b1, 1'b0);
      check("stream_valid1", {31'b0, d_valid}, 32'h1);
      cycle(1'b1, 32'h8, 32'hA2, 32'hC, 1'b1, 1'b0);
      check("stream_valid2", {31'b0, d_valid}, 32'h1);
      cycle(1'b1, 32'hC, 32'hA3, 32'h10, 1'b1, 1'b0);
      check("stream_valid3", {31'b0, d_valid}, 32'h1);
      check("stream_last_pc", d_pc, 32'hC);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("stream_drained", {31'b0, d_valid}, 32'h0);

      // Backpressure
      cycle(1'b1, 32'h10, 32'hB0, 32'h14, 1'b0, 1'b0);
      check("bp_pc_first", d_pc, 32'h10);
`ifdef IF_ID_SKID_EN
      cycle(1'b1, 32'h14, 32'hB1, 32'h18, 1'b0, 1'b0);
      check("bp_count_full", {30'b0, count}, 32'h2);
      check("bp_f_ready_full", {31'b0, f_ready}, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("bp_pc_hold", d_pc, 32'h10);
      check("bp_count_hold", {30'b0, count}, 32'h2);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_pc_second", d_pc, 32'h14);
`else
      check("bp_count_one", {30'b0, count}, 32'h1);
      check("bp_f_ready_stall", {31'b0, f_ready}, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      check("bp_pc_hold", d_pc, 32'h10);
      cycle(1'b1, 32'h14, 32'hB1, 32'h18, 1'b1, 1'b0);
      check("bp_pc_second", d_pc, 32'h14);
`endif
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("bp_drained", {31'b0, d_valid}, 32'h0);

      // Flush with a beat offered in the flush cycle
      cycle(1'b1, 32'h20, 32'hC0, 32'h24, 1'b0, 1'b0);
`ifdef IF_ID_SKID_EN
      cycle(1'b1, 32'h24, 32'hC1, 32'h28, 1'b0, 1'b0);
      check("fl_count_full", {30'b0, count}, 32'h2);
`endif
      cycle(1'b1, 32'h18, 32'hC2, 32'h1C, 1'b1, 1'b1);
      check("fl_d_valid", {31'b0, d_valid}, 32'h0);
      check("fl_count", {30'b0, count}, 32'h0);
      check("fl_f_ready", {31'b0, f_ready}, 32'h1);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("fl_no_stale", {31'b0, d_valid}, 32'h0);

      // PC+4 wrap
      cycle(1'b1, 32'hFFFF_FFFC, 32'hD0, 32'h0, 1'b0, 1'b0);
      check("wrap_pc4", d_pc4, 32'h0);
      cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset between edges while holding beats
      cycle(1'b1, 32'h30, 32'hE0, 32'h34, 1'b0, 1'b0);
`ifdef IF_ID_SKID_EN
      cycle(1'b1, 32'h34, 32'hE1, 32'h38, 1'b0, 1'b0);
      check("ar_count_full", {30'b0, count}, 32'h2);
`else
      check("ar_count_one", {30'b0, count}, 32'h1);
`endif
      f_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_d_valid", {31'b0, d_valid}, 32'h0);
      check("ar_count", {30'b0, count}, 32'h0);
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
         check("ar_no_stale", {31'b0, d_valid}, 32'h0);
      end

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
